pcpi_serial_bridge: RTL and testbench

//  Parametrised successor to the nibble-serial PCPI loader. Assembles an INSN_W instruction from
//  SEG_W-bit segments over a valid/ready handshake, issues it on a full PCPI handshake, then returns

---
 rtl/pcpi_serial_bridge_if.sv | 33 +++
 rtl/pcpi_serial_bridge.sv | 144 ++++++++++++++
 tb/tb_pcpi_serial_bridge.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pcpi_serial_bridge_if.sv
// Segment, PCPI and result-stream signals of the serial PCPI bridge.
// The master modport is the bridge side; the slave modport is the pad/coprocessor side.
interface pcpi_serial_bridge_if #(
    parameter int SEG_W  = 4,
    parameter int INSN_W = 32,
    parameter int XLEN   = 32
);
    logic              seg_valid;
    logic [SEG_W-1:0]  seg_data;
    logic              seg_ready;

    logic              pcpi_valid;
    logic [INSN_W-1:0] pcpi_insn;
    logic              pcpi_ready;
    logic              pcpi_wr;
    logic [XLEN-1:0]   pcpi_rd;
    logic              pcpi_wait;

    logic              out_valid;
    logic [SEG_W-1:0]  out_data;
    logic              out_last;
    logic              out_ready;

    modport master (
        input  seg_valid, seg_data, pcpi_ready, pcpi_wr, pcpi_rd, pcpi_wait, out_ready,
        output seg_ready, pcpi_valid, pcpi_insn, out_valid, out_data, out_last
    );

    modport slave (
        output seg_valid, seg_data, pcpi_ready, pcpi_wr, pcpi_rd, pcpi_wait, out_ready,
        input  seg_ready, pcpi_valid, pcpi_insn, out_valid, out_data, out_last
    );
endinterface

// File: rtl/pcpi_serial_bridge.sv
// Serial-to-PCPI bridge: assembles an instruction from segments, issues it over PCPI with
// timeout detection, and streams the write-back result out segment by segment.
module pcpi_serial_bridge #(
    parameter int SEG_W   = 4,
    parameter int INSN_W  = 32,
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     abort,
    pcpi_serial_bridge_if.master     bus,
    output logic                     done,
    output logic                     err,
    output logic                     busy
);
    localparam int NSEG = INSN_W / SEG_W;
    localparam int NOUT = XLEN / SEG_W;
    localparam int KW   = (NSEG > 1)    ? $clog2(NSEG)    : 1;
    localparam int JW   = (NOUT > 1)    ? $clog2(NOUT)    : 1;
    localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [KW-1:0] K_LAST = KW'(NSEG - 1);
    localparam logic [JW-1:0] J_LAST = JW'(NOUT - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        ISSUE = 2'd1,
        SEND  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [KW-1:0]     k, k_nxt;
    logic [JW-1:0]     j, j_nxt;
    logic [TW-1:0]     t, t_nxt;
    logic              wait_seen, wait_seen_nxt;
    logic [INSN_W-1:0] insn, insn_nxt;
    logic [XLEN-1:0]   result, result_nxt;
    logic              done_nxt, err_nxt;
    logic              waiting;

    // NOTE: non-blocking assignments only here, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LOAD;
            k         <= '0;
            j         <= '0;
            t         <= '0;
            wait_seen <= 1'b0;
            insn      <= '0;
            result    <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            k         <= k_nxt;
            j         <= j_nxt;
            t         <= t_nxt;
            wait_seen <= wait_seen_nxt;
            insn      <= insn_nxt;
            result    <= result_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
        end
    end

    // A busy coprocessor suppresses the timeout from the first cycle it raises pcpi_wait.
    assign waiting = wait_seen | bus.pcpi_wait;

    // NOTE: every variable gets its default first, so no path through this block infers a latch.
    always_comb begin
        state_nxt     = state;
        k_nxt         = k;
        j_nxt         = j;
        t_nxt         = t;
        wait_seen_nxt = wait_seen;
        insn_nxt      = insn;
        result_nxt    = result;
        done_nxt      = 1'b0;
        err_nxt       = 1'b0;

        case (state)
            LOAD: begin
                if (bus.seg_valid) begin
                    insn_nxt[int'(k)*SEG_W +: SEG_W] = bus.seg_data;
                    if (k == K_LAST) state_nxt = ISSUE;
                    else             k_nxt     = k + 1'b1;
                end
            end
            ISSUE: begin
                if (bus.pcpi_ready) begin
                    result_nxt = bus.pcpi_rd;
                    if (bus.pcpi_wr) begin
                        state_nxt = SEND;
                    end else begin
                        state_nxt = LOAD;
                        done_nxt  = 1'b1;
                    end
                end else if (!waiting && t == T_LAST) begin
                    state_nxt = LOAD;
                    err_nxt   = 1'b1;
                end else if (waiting) begin
                    wait_seen_nxt = 1'b1;
                end else begin
                    t_nxt = t + 1'b1;
                end
            end
            SEND: begin
                if (bus.out_ready) begin
                    if (j == J_LAST) begin
                        state_nxt = LOAD;
                        done_nxt  = 1'b1;
                    end else begin
                        j_nxt = j + 1'b1;
                    end
                end
            end
            default: state_nxt = LOAD;
        endcase

        if (abort) begin
            state_nxt = LOAD;
            done_nxt  = 1'b0;
            err_nxt   = 1'b0;
        end

        // Entering LOAD (or aborting within it) restarts all sequencing from zero.
        if (state_nxt == LOAD && (state != LOAD || abort)) begin
            k_nxt         = '0;
            j_nxt         = '0;
            t_nxt         = '0;
            wait_seen_nxt = 1'b0;
        end
    end

    assign bus.seg_ready  = (state == LOAD);
    assign bus.pcpi_valid = (state == ISSUE);
    assign bus.pcpi_insn  = insn;
    assign bus.out_valid  = (state == SEND);
    assign bus.out_data   = (state == SEND) ? result[int'(j)*SEG_W +: SEG_W] : '0;
    assign bus.out_last   = (state == SEND) && (j == J_LAST);
    assign busy           = (state == ISSUE) || (state == SEND);
endmodule

// File: tb/tb_pcpi_serial_bridge.sv
// Directed bench for pcpi_serial_bridge: vector table of full transactions plus
// hand-written timeout, wait, abort and reset sequences.
module tb_pcpi_serial_bridge;
    logic clk = 1'b0;
    logic rst;
    logic abort;
    logic done, err, busy;

    int checks = 0;
    int errors = 0;

    pcpi_serial_bridge_if #(.SEG_W(4), .INSN_W(32), .XLEN(32)) bus ();

    pcpi_serial_bridge #(.SEG_W(4), .INSN_W(32), .XLEN(32), .TIMEOUT(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .abort (abort),
        .bus   (bus),
        .done  (done),
        .err   (err),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] insn;
        int          delay;
        logic        wr;
        logic [31:0] rd;
        bit          toggle;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [31:0] w);
        for (int i = 0; i < 8; i++) begin
            bus.seg_valid = 1'b1;
            bus.seg_data  = w[i*4 +: 4];
            if (i == 7) check("pcpi_valid before last beat", bus.pcpi_valid, 0);
            tick();
        end
        bus.seg_valid = 1'b0;
        bus.seg_data  = '0;
        check("pcpi_valid after last beat", bus.pcpi_valid, 1);
        check("pcpi_insn", bus.pcpi_insn, w);
        check("seg_ready in ISSUE", bus.seg_ready, 0);
    endtask

    task automatic respond(input int delay, input logic wr, input logic [31:0] rd);
        for (int c = 0; c < delay; c++) tick();
        bus.pcpi_ready = 1'b1;
        bus.pcpi_wr    = wr;
        bus.pcpi_rd    = rd;
        tick();
        bus.pcpi_ready = 1'b0;
        bus.pcpi_wr    = 1'b0;
        bus.pcpi_rd    = '0;
        check("pcpi_valid drops after ready", bus.pcpi_valid, 0);
    endtask

    task automatic recv(input logic [31:0] exp, input bit toggle);
        int n = 0;
        int guard = 0;
        bit stalled = 1'b0;
        logic [3:0] prev = '0;
        logic rdy;
        while (n < 8 && guard < 64) begin
            rdy = toggle ? ~guard[0] : 1'b1;
            bus.out_ready = rdy;
            if (bus.out_valid !== 1'b1) begin
                check("out_valid in SEND", bus.out_valid, 1);
                break;
            end
            if (stalled) check("out_data stable", bus.out_data, prev);
            if (rdy) begin
                check("out_nibble", bus.out_data, exp[n*4 +: 4]);
                check("out_last", bus.out_last, (n == 7));
                n++;
            end
            stalled = !rdy;
            prev    = bus.out_data;
            tick();
            guard++;
        end
        bus.out_ready = 1'b0;
        check("out beats", n, 8);
        check("done after send", done, 1);
        check("out_valid after send", bus.out_valid, 0);
        check("seg_ready after send", bus.seg_ready, 1);
        tick();
        check("done pulse width", done, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit saw_err;
        bit saw_done;

        vecs[0] = '{32'h00000033, 5, 1'b1, 32'hDEADBEEF, 1'b0};
        vecs[1] = '{32'h12345678, 0, 1'b1, 32'h0F1E2D3C, 1'b1};
        vecs[2] = '{32'hFFFFFFFF, 3, 1'b0, 32'hAAAA5555, 1'b0};
        vecs[3] = '{32'hA5A5A5A5, 1, 1'b1, 32'h80000001, 1'b1};

        rst = 1'b1; abort = 1'b0;
        bus.seg_valid = 1'b0; bus.seg_data = '0;
        bus.pcpi_ready = 1'b0; bus.pcpi_wr = 1'b0; bus.pcpi_rd = '0; bus.pcpi_wait = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        check("reset seg_ready", bus.seg_ready, 1);
        check("reset pcpi_valid", bus.pcpi_valid, 0);
        check("reset pcpi_insn", bus.pcpi_insn, 0);
        check("reset out_valid", bus.out_valid, 0);
        check("reset out_last", bus.out_last, 0);
        check("reset done/err/busy", {done, err, busy}, 0);
        rst = 1'b0;

        for (int v = 0; v < 4; v++) begin
            load_word(vecs[v].insn);
            check("busy in ISSUE", busy, 1);
            respond(vecs[v].delay, vecs[v].wr, vecs[v].rd);
            check("no err", err, 0);
            if (vecs[v].wr) begin
                check("busy in SEND", busy, 1);
                check("done before send", done, 0);
                recv(vecs[v].rd, vecs[v].toggle);
            end else begin
                check("done no readback", done, 1);
                check("out_valid no readback", bus.out_valid, 0);
                check("seg_ready no readback", bus.seg_ready, 1);
                tick();
                check("done pulse width", done, 0);
            end
        end

        // Silent coprocessor: err arrives 16 cycles after pcpi_valid rose.
        load_word(32'h00000013);
        for (int c = 0; c < 15; c++) tick();
        check("err before timeout", err, 0);
        check("pcpi_valid before timeout", bus.pcpi_valid, 1);
        tick();
        check("err on timeout", err, 1);
        check("done on timeout", done, 0);
        check("seg_ready after timeout", bus.seg_ready, 1);
        check("pcpi_valid after timeout", bus.pcpi_valid, 0);
        tick();
        check("err pulse width", err, 0);

        // pcpi_wait suppresses the timeout; late ready without write-back.
        load_word(32'h00000093);
        tick();
        tick();
        bus.pcpi_wait = 1'b1;
        saw_err = 1'b0;
        saw_done = 1'b0;
        for (int c = 2; c < 40; c++) begin
            tick();
            saw_err  |= err;
            saw_done |= done;
        end
        check("err while waiting", saw_err, 0);
        check("done while waiting", saw_done, 0);
        check("still issuing at 40", bus.pcpi_valid, 1);
        bus.pcpi_wait = 1'b0;
        respond(0, 1'b0, 32'h11111111);
        check("done after wait", done, 1);
        check("err after wait", err, 0);
        check("out_valid after wait", bus.out_valid, 0);
        tick();

        // Abort mid-load discards the partial instruction.
        for (int i = 0; i < 3; i++) begin
            bus.seg_valid = 1'b1;
            bus.seg_data  = 4'h9;
            tick();
        end
        bus.seg_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("seg_ready after load abort", bus.seg_ready, 1);
        check("pcpi_valid after load abort", bus.pcpi_valid, 0);
        load_word(32'h87654321);

        // Abort beats a same-cycle pcpi_ready.
        tick();
        bus.pcpi_ready = 1'b1; bus.pcpi_wr = 1'b1; bus.pcpi_rd = 32'h5A5A5A5A;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        bus.pcpi_ready = 1'b0; bus.pcpi_wr = 1'b0;
        check("done on abort vs ready", done, 0);
        check("out_valid on abort vs ready", bus.out_valid, 0);
        check("pcpi_valid on abort vs ready", bus.pcpi_valid, 0);
        check("seg_ready on abort vs ready", bus.seg_ready, 1);
        check("busy on abort vs ready", busy, 0);

        // Abort beats the last out beat.
        load_word(32'h00C0FFEE);
        respond(2, 1'b1, 32'h13579BDF);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        check("last beat flagged", bus.out_last, 1);
        check("last beat data", bus.out_data, 4'h1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        bus.out_ready = 1'b0;
        check("done on abort vs last beat", done, 0);
        check("out_valid on abort vs last beat", bus.out_valid, 0);

        // Reset mid-SEND returns to reset values.
        load_word(32'hCAFEF00D);
        respond(1, 1'b1, 32'h2468ACE0);
        tick();
        check("in SEND before reset", bus.out_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("reset mid-op out_valid", bus.out_valid, 0);
        check("reset mid-op seg_ready", bus.seg_ready, 1);
        check("reset mid-op pcpi_insn", bus.pcpi_insn, 0);
        check("reset mid-op out_data", bus.out_data, 0);
        check("reset mid-op done/err/busy", {done, err, busy}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
